// File: rtl/lcd_refresh_seq_if.sv
// Byte path between the LCD refresh sequencer, its framebuffer read port
// and the SPI byte engine.
interface lcd_refresh_seq_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] fb_addr_o;
  logic              fb_rd_o;
  logic [7:0]        fb_data_i;
  logic [7:0]        byte_o;
  logic              dc_o;
  logic              byte_valid_o;
  logic              byte_ready_i;

  modport master (
    output fb_addr_o, fb_rd_o, byte_o, dc_o, byte_valid_o,
    input  fb_data_i, byte_ready_i
  );

  modport slave (
    input  fb_addr_o, fb_rd_o, byte_o, dc_o, byte_valid_o,
    output fb_data_i, byte_ready_i
  );
endinterface

// File: rtl/lcd_refresh_seq.sv
// PCD8544 refresh sequencer: sends the controller init list once (or on
// request), then homes the cursor and streams the framebuffer as data bytes.
module lcd_refresh_seq #(
  parameter int         FB_BYTES = 504,
  parameter int         ADDR_W   = 9,
  parameter logic [6:0] VOP      = 7'h38
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               reinit_i,
  input  logic               rst_done_i,
  lcd_refresh_seq_if.master  bus,
  output logic               busy_o,
  output logic               done_o,
  output logic [15:0]        frame_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RST, S_INIT, S_HOME, S_FETCH, S_LOAD, S_SEND, S_DONE
  } state_t;

  localparam logic [7:0] INIT_TAB [6] = '{
    8'h21, (8'h80 | {1'b0, VOP}), 8'h04, 8'h14, 8'h20, 8'h0C
  };
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);

  state_t            state_q, state_d;
  logic              init_done_q, init_done_d;
  logic              reinit_pend_q, reinit_pend_d;
  logic [2:0]        cmd_cnt_q, cmd_cnt_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic              fb_rd_q, fb_rd_d;
  logic [7:0]        byte_q, byte_d;
  logic              dc_q, dc_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              xfer;

  assign xfer = valid_q & bus.byte_ready_i;

  always_comb begin
    state_d       = state_q;
    init_done_d   = init_done_q;
    reinit_pend_d = reinit_pend_q | reinit_i;
    cmd_cnt_d     = cmd_cnt_q;
    fb_addr_d     = fb_addr_q;
    fb_rd_d       = 1'b0;
    byte_d        = byte_q;
    dc_d          = dc_q;
    valid_d       = valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WAIT_RST;
          busy_d  = 1'b1;
        end
      end

      S_WAIT_RST: begin
        if (rst_done_i) begin
          cmd_cnt_d = 3'd0;
          state_d   = (!init_done_q || reinit_pend_q) ? S_INIT : S_HOME;
        end
      end

      // Commands are loaded one cycle, then held until the engine takes them.
      S_INIT: begin
        if (!valid_q) begin
          byte_d  = INIT_TAB[cmd_cnt_q];
          dc_d    = 1'b0;
          valid_d = 1'b1;
        end else if (xfer) begin
          valid_d = 1'b0;
          if (cmd_cnt_q == 3'd5) begin
            init_done_d   = 1'b1;
            reinit_pend_d = reinit_i;
            cmd_cnt_d     = 3'd0;
            state_d       = S_HOME;
          end else begin
            cmd_cnt_d = cmd_cnt_q + 3'd1;
          end
        end
      end

      S_HOME: begin
        if (!valid_q) begin
          byte_d  = cmd_cnt_q[0] ? 8'h80 : 8'h40;
          dc_d    = 1'b0;
          valid_d = 1'b1;
        end else if (xfer) begin
          valid_d = 1'b0;
          if (cmd_cnt_q[0]) begin
            cmd_cnt_d = 3'd0;
            fb_addr_d = '0;
            fb_rd_d   = 1'b1;
            state_d   = S_FETCH;
          end else begin
            cmd_cnt_d = 3'd1;
          end
        end
      end

      // Read strobe is high here; RAM data arrives during S_LOAD.
      S_FETCH: state_d = S_LOAD;

      S_LOAD: begin
        byte_d  = bus.fb_data_i;
        dc_d    = 1'b1;
        valid_d = 1'b1;
        state_d = S_SEND;
      end

      S_SEND: begin
        if (xfer) begin
          valid_d = 1'b0;
          if (fb_addr_q == LAST_ADDR) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            fb_addr_d = fb_addr_q + ADDR_W'(1);
            fb_rd_d   = 1'b1;
            state_d   = S_FETCH;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      init_done_q   <= 1'b0;
      reinit_pend_q <= 1'b0;
      cmd_cnt_q     <= 3'd0;
      fb_addr_q     <= '0;
      fb_rd_q       <= 1'b0;
      byte_q        <= 8'h00;
      dc_q          <= 1'b0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_cnt_q   <= 16'h0000;
    end else begin
      state_q       <= state_d;
      init_done_q   <= init_done_d;
      reinit_pend_q <= reinit_pend_d;
      cmd_cnt_q     <= cmd_cnt_d;
      fb_addr_q     <= fb_addr_d;
      fb_rd_q       <= fb_rd_d;
      byte_q        <= byte_d;
      dc_q          <= dc_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.fb_addr_o    = fb_addr_q;
  assign bus.fb_rd_o      = fb_rd_q;
  assign bus.byte_o       = byte_q;
  assign bus.dc_o         = dc_q;
  assign bus.byte_valid_o = valid_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign frame_cnt_o      = frame_cnt_q;

endmodule

// File: tb/tb_lcd_refresh_seq.sv
// Directed/randomized bench for lcd_refresh_seq with a frame-level transfer
// model, framebuffer RAM model and handshake monitor.
module tb_lcd_refresh_seq;
  logic        clk = 1'b0;
  logic        reset, start_i, reinit_i, rst_done_i;
  logic        busy_o, done_o;
  logic [15:0] frame_cnt_o;

  lcd_refresh_seq_if #(.ADDR_W(9)) bus ();

  lcd_refresh_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .reinit_i    (reinit_i),
    .rst_done_i  (rst_done_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] mem [504];
  logic [8:0] got_q [$];
  logic [8:0] exp_q [$];
  int         rd_q  [$];
  int         done_cnt, data_cnt;
  bit         rdy_random = 1'b0;
  bit         prev_stall = 1'b0;
  logic [8:0] prev_word;
  bit         m_init_done = 1'b0;
  bit         m_reinit    = 1'b0;
  int         m_frames    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Framebuffer RAM: one-cycle registered read.
  initial bus.fb_data_i = 8'h00;
  always @(posedge clk) if (bus.fb_rd_o) bus.fb_data_i <= mem[bus.fb_addr_o];

  initial begin
    bus.byte_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.byte_ready_i = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.byte_valid_o && bus.byte_ready_i) begin
        got_q.push_back({bus.dc_o, bus.byte_o});
        if (bus.dc_o) data_cnt++;
      end
      if (bus.fb_rd_o) begin
        rd_q.push_back(int'(bus.fb_addr_o));
        check("fb_addr_in_range", 32'(bus.fb_addr_o <= 9'd503), 32'd1);
      end
      if (prev_stall) begin
        check("stall_valid_held", 32'(bus.byte_valid_o), 32'd1);
        check("stall_word_held", 32'({bus.dc_o, bus.byte_o}), 32'(prev_word));
      end
      if (done_o) begin
        done_cnt++;
        check("done_busy_exclusive", 32'(busy_o), 32'd0);
      end
      prev_stall = bus.byte_valid_o && !bus.byte_ready_i;
      prev_word  = {bus.dc_o, bus.byte_o};
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fb_addr"}, 32'(bus.fb_addr_o), 32'd0);
    check({tag, "_fb_rd"}, 32'(bus.fb_rd_o), 32'd0);
    check({tag, "_byte"}, 32'(bus.byte_o), 32'd0);
    check({tag, "_dc"}, 32'(bus.dc_o), 32'd0);
    check({tag, "_valid"}, 32'(bus.byte_valid_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt_o), 32'd0);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 504; i++) mem[i] = 8'($urandom);
  endtask

  // Builds the expected transfer list from the model's init state, then pulses start.
  task automatic start_frame(input bit with_reinit);
    bit with_init;
    logic [7:0] init_list [6];
    init_list = '{8'h21, 8'h80 | 8'h38, 8'h04, 8'h14, 8'h20, 8'h0C};
    if (with_reinit) m_reinit = 1'b1;
    with_init = !m_init_done || m_reinit;
    exp_q.delete();
    if (with_init) for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, init_list[i]});
    exp_q.push_back(9'h040);
    exp_q.push_back(9'h080);
    for (int i = 0; i < 504; i++) exp_q.push_back({1'b1, mem[i]});
    got_q.delete();
    rd_q.delete();
    done_cnt = 0;
    data_cnt = 0;
    if (with_init) begin
      m_init_done = 1'b1;
      m_reinit    = 1'b0;
    end
    @(posedge clk); #1;
    start_i  = 1'b1;
    reinit_i = with_reinit;
    @(posedge clk); #1;
    start_i  = 1'b0;
    reinit_i = 1'b0;
  endtask

  task automatic wait_data(input int n, input string tag);
    int cyc = 0;
    while (data_cnt < n && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_reached"}, 32'(data_cnt >= n), 32'd1);
  endtask

  task automatic finish_frame(input string tag);
    int cyc = 0;
    int mism = 0;
    int n;
    while (done_cnt == 0 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_after"}, 32'(busy_o), 32'd0);
    m_frames++;
    check({tag, "_frame_cnt"}, 32'(frame_cnt_o), 32'(m_frames & 16'hFFFF));
    check({tag, "_xfer_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) mism++;
    check({tag, "_xfer_mismatches"}, 32'(mism), 32'd0);
    check({tag, "_rd_count"}, 32'(rd_q.size()), 32'd504);
    mism = 0;
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] != i) mism++;
    check({tag, "_rd_order"}, 32'(mism), 32'd0);
    $display("frame %s: %0d transfers, %0d fb reads, frame_cnt=%0d",
             tag, got_q.size(), rd_q.size(), frame_cnt_o);
  endtask

  initial begin
    int bad;
    reset = 1'b1; start_i = 1'b0; reinit_i = 1'b0; rst_done_i = 1'b1;
    fill_mem();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    start_frame(1'b0);
    finish_frame("first_with_init");

    fill_mem();
    start_frame(1'b0);
    finish_frame("second_no_init");

    rdy_random = 1'b1;
    fill_mem();
    start_frame(1'b0);
    finish_frame("random_ready");

    rst_done_i = 1'b0;
    fill_mem();
    start_frame(1'b0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (busy_o !== 1'b1 || bus.byte_valid_o !== 1'b0) bad++;
    end
    check("wait_rst_hold", 32'(bad), 32'd0);
    check("wait_rst_no_xfer", 32'(got_q.size()), 32'd0);
    rst_done_i = 1'b1;
    finish_frame("after_rst_done");

    // Reinit, ignored start and rst_done drop all during one frame.
    fill_mem();
    start_frame(1'b0);
    wait_data(100, "reinit_point");
    start_i = 1'b1; reinit_i = 1'b1; rst_done_i = 1'b0;
    m_reinit = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; reinit_i = 1'b0;
    finish_frame("reinit_mid_frame");
    rst_done_i = 1'b1;

    fill_mem();
    start_frame(1'b0);
    finish_frame("reinit_applied");

    fill_mem();
    start_frame(1'b1);
    finish_frame("start_with_reinit");

    fill_mem();
    start_frame(1'b0);
    wait_data(200, "reset_point");
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    m_init_done = 1'b0;
    m_reinit    = 1'b0;
    m_frames    = 0;

    fill_mem();
    start_frame(1'b0);
    finish_frame("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
